// File: rtl/seq_pkg.sv
// Shared types, parameter defaults and helpers for the fetch/execute sequencer.
package seq_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} seq_state_t;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 16;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'((64'(1) << w) - 64'(1));
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_wait_ctr.sv
// Loadable down-counter pacing the memory wait state; stops at zero.
module seq_wait_ctr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the PC, gates decoder strobes so
// each instruction commits once, and keeps cycle/instruction counters.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             halt,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             alu_branch,
  input  logic [PC_W-1:0]  target_pc,
  input  logic             mem_op,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             do_swap,
  output logic [PC_W-1:0]  pc,
  output logic             ir_load,
  output logic             reg_we,
  output logic             mem_we,
  output logic             swap_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WAIT_W = (MEM_LAT != 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_next;
  logic [CNT_W-1:0] cyc_q, cyc_d, instr_q, instr_d;
  logic             ir_load_q, ir_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             commit, wait_load, wait_dec, wait_zero;

  seq_wait_ctr #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (wait_load),
    .load_val (WAIT_INIT),
    .dec      (wait_dec),
    .zero_c   (wait_zero)
  );

  // Next PC at commit: jump wins, taken branch next, else wrap-around increment.
  always_comb begin
    pc_next = pc_q + PC_W'(1);
    if (jump_en || (branch_en && alu_branch)) begin
      pc_next = target_pc;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cyc_d     = cyc_q;
    instr_d   = instr_q;
    commit    = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;

    if (busy_q) begin
      cyc_d = CNT_W'(sat_inc(32'(cyc_q), CNT_W));
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = start_addr;
          cyc_d   = '0;
          instr_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (halt) begin
          state_d = DONE;
        end else if (mem_op && (MEM_LAT != 0)) begin
          wait_load = 1'b1;
          state_d   = MEM;
        end else begin
          commit = 1'b1;
        end
      end
      MEM: begin
        if (wait_zero) begin
          commit = 1'b1;
        end else begin
          wait_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      pc_d    = pc_next;
      instr_d = CNT_W'(sat_inc(32'(instr_q), CNT_W));
      state_d = FETCH;
    end

    ir_load_d = (state_d == FETCH);
    busy_d    = (state_d == FETCH) || (state_d == EXEC) || (state_d == MEM);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cyc_q     <= '0;
      instr_q   <= '0;
      ir_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cyc_q     <= cyc_d;
      instr_q   <= instr_d;
      ir_load_q <= ir_load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Commit strobes must land in the same cycle the decoder outputs are valid.
  assign reg_we    = commit & reg_write;
  assign mem_we    = commit & mem_write;
  assign swap_en   = commit & do_swap;

  assign pc        = pc_q;
  assign ir_load   = ir_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed per-cycle vector bench for seq_ctrl (PC_W=10, MEM_LAT=2, CNT_W=16).
module tb_seq_ctrl;

  typedef struct packed {
    logic       start;
    logic [9:0] start_addr;
    logic [3:0] ctl;  // {halt, jump_en, branch_en, alu_branch}
    logic [9:0] target_pc;
    logic [3:0] dec;  // {mem_op, reg_write, mem_write, do_swap}
  } stim_t;

  typedef struct {
    stim_t       stim;
    logic [47:0] exp; // {pc, ir_load, reg_we, mem_we, swap_en, busy, done, cyc, instr}
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, halt, jump_en, branch_en, alu_branch;
  logic        mem_op, reg_write, mem_write, do_swap;
  logic [9:0]  start_addr, target_pc;
  logic [9:0]  pc;
  logic        ir_load, reg_we, mem_we, swap_en, busy, done;
  logic [15:0] cyc_cnt, instr_cnt;
  logic [47:0] act;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  seq_ctrl #(.PC_W(10), .MEM_LAT(2), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .halt       (halt),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .alu_branch (alu_branch),
    .target_pc  (target_pc),
    .mem_op     (mem_op),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .do_swap    (do_swap),
    .pc         (pc),
    .ir_load    (ir_load),
    .reg_we     (reg_we),
    .mem_we     (mem_we),
    .swap_en    (swap_en),
    .busy       (busy),
    .done       (done),
    .cyc_cnt    (cyc_cnt),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = {pc, ir_load, reg_we, mem_we, swap_en, busy, done, cyc_cnt, instr_cnt};

  function automatic vec_t mk(input logic st, input logic [9:0] sa, input logic [3:0] ctl,
                              input logic [9:0] tgt, input logic [3:0] dec, input logic [9:0] epc,
                              input logic [5:0] eflags, input logic [15:0] ecyc,
                              input logic [15:0] einstr);
    vec_t v;
    v.stim = {st, sa, ctl, tgt, dec};
    v.exp  = {epc, eflags, ecyc, einstr};
    return v;
  endfunction

  task automatic apply(input stim_t s);
    start = s.start;
    start_addr = s.start_addr;
    {halt, jump_en, branch_en, alu_branch} = s.ctl;
    target_pc = s.target_pc;
    {mem_op, reg_write, mem_write, do_swap} = s.dec;
  endtask

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got pc=%h flags=%b cyc=%0d instr=%0d, want pc=%h flags=%b cyc=%0d instr=%0d",
               name, got[47:38], got[37:32], got[31:16], got[15:0],
               want[47:38], want[37:32], want[31:16], want[15:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flags column: {ir_load, reg_we, mem_we, swap_en, busy, done}
    tbl.push_back(mk(1, 10'h005, 4'b0000, 10'h000, 4'b0000, 10'h000, 6'b000000,  0, 0));
    tbl.push_back(mk(1, 10'h077, 4'b0000, 10'h000, 4'b0100, 10'h005, 6'b100010,  0, 0));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0100, 10'h005, 6'b010010,  1, 0));
    tbl.push_back(mk(0, 10'h000, 4'b1000, 10'h000, 4'b0100, 10'h006, 6'b100010,  2, 1));
    tbl.push_back(mk(0, 10'h000, 4'b1000, 10'h000, 4'b0100, 10'h006, 6'b000010,  3, 1));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0110, 10'h006, 6'b000001,  4, 1));
    tbl.push_back(mk(1, 10'h010, 4'b0000, 10'h000, 4'b0000, 10'h006, 6'b000001,  4, 1));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h010, 6'b100010,  0, 0));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b1010, 10'h010, 6'b000010,  1, 0));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b1010, 10'h010, 6'b000010,  2, 0));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b1010, 10'h010, 6'b001010,  3, 0));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h011, 6'b100010,  4, 1));
    tbl.push_back(mk(0, 10'h000, 4'b0010, 10'h03A, 4'b0001, 10'h011, 6'b000110,  5, 1));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h012, 6'b100010,  6, 2));
    tbl.push_back(mk(0, 10'h000, 4'b0011, 10'h03A, 4'b0000, 10'h012, 6'b000010,  7, 2));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h03A, 6'b100010,  8, 3));
    tbl.push_back(mk(0, 10'h000, 4'b0110, 10'h3FF, 4'b0100, 10'h03A, 6'b010010,  9, 3));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h3FF, 6'b100010, 10, 4));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h03A, 4'b0000, 10'h3FF, 6'b000010, 11, 4));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h000, 6'b100010, 12, 5));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b1100, 10'h000, 6'b000010, 13, 5));
    tbl.push_back(mk(1, 10'h055, 4'b0000, 10'h000, 4'b1100, 10'h000, 6'b000010, 14, 5));
    tbl.push_back(mk(0, 10'h000, 4'b0100, 10'h020, 4'b1100, 10'h000, 6'b010010, 15, 5));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h020, 6'b100010, 16, 6));
    tbl.push_back(mk(0, 10'h000, 4'b1000, 10'h000, 4'b0000, 10'h020, 6'b000010, 17, 6));
    tbl.push_back(mk(0, 10'h000, 4'b0000, 10'h000, 4'b0000, 10'h020, 6'b000001, 18, 6));

    reset_n = 1'b0;
    apply('0);
    #12;
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      apply(tbl[i].stim);
      #1;
      check($sformatf("row%0d", i), act, tbl[i].exp);
      step();
    end

    // Relaunch from DONE into a store, then reset while it waits in MEM.
    apply({1'b1, 10'h030, 4'b0000, 10'h000, 4'b0000});
    step();
    apply('0);
    step();
    apply({1'b0, 10'h000, 4'b0000, 10'h000, 4'b1010});
    #1;
    check("store_exec", act, {10'h030, 6'b000010, 16'd1, 16'd0});
    step();
    check("store_mem1", act, {10'h030, 6'b000010, 16'd2, 16'd0});
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async", act, 48'h0);
    step();
    check("reset_held", act, 48'h0);
    #3;
    reset_n = 1'b1;
    step();
    check("post_reset_idle", act, 48'h0);
    step();
    check("post_reset_idle2", act, 48'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle fetch/execute sequencer for the 9-bit-instruction core. It owns the program counter and paces instruction-register load, execution and memory access. It gates the combinational decoder's RegWrite, MemWrite and doSWAP strobes so that each instruction commits exactly once. It also provides the start/done handshake to the testbench/top level and performance counters.

Parameters:
PC_W, 10, program counter width (instruction memory depth 2^PC_W)
MEM_LAT, 2, extra wait cycles for load/store instructions (0 = no MEM state)
CNT_W, 16, width of cycle and instruction counters

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; launches program from start_addr when idle/done
start_addr  in  PC_W  first instruction address
halt  in  1  decoded instruction is the program-end marker
jump_en  in  1  decoder: unconditional branch
branch_en  in  1  decoder: conditional branch (BEQ/SLT-type)
alu_branch  in  1  ALU branch condition true
target_pc  in  PC_W  branch target from lookup table
mem_op  in  1  decoder: instruction is load or store
reg_write  in  1  decoder RegWrite
mem_write  in  1  decoder MemWrite
do_swap  in  1  decoder doSWAP
pc  out  PC_W  current instruction address
ir_load  out  1  load instruction register this cycle
reg_we  out  1  gated register-file write enable
mem_we  out  1  gated data-memory write enable
swap_en  out  1  gated swap strobe
busy  out  1  program running
done  out  1  program finished, held high
cyc_cnt  out  CNT_W  cycles spent running
instr_cnt  out  CNT_W  instructions retired

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, DONE.
- Reset (async, reset_n=0): state=IDLE; pc=0; all strobes 0; busy=0; done=0; counters=0; MEM wait counter=0. Reset mid-program aborts immediately, with no partial commit.
- IDLE: if start=1, then pc<=start_addr, counters<=0, next state FETCH.
- FETCH: ir_load=1 for exactly one cycle, then EXEC.
- EXEC:
  - Decoder inputs are valid in this state.
  - If halt=1: go to DONE. Nothing commits and the halt instruction is not counted.
  - Else if mem_op=1 and MEM_LAT>0: load wait counter with MEM_LAT-1, then go to MEM. No strobes this cycle.
  - Otherwise commit: reg_we=reg_write, mem_we=mem_write, swap_en=do_swap, instr_cnt+1, pc update, go to FETCH.
- MEM:
  - Decrement the wait counter each cycle.
  - When the counter reads 0, commit exactly as in EXEC (same cycle) and go to FETCH.
  - Total load/store latency: 2+MEM_LAT cycles. Non-memory instruction latency: 2 cycles.
- PC update at commit: if jump_en=1, or branch_en=1 and alu_branch=1, then pc<=target_pc; else pc<=pc+1.
  - The increment wraps from 2^PC_W-1 to 0 silently.
  - jump_en has priority; both branch conditions active gives target_pc.
- Strobes (reg_we, mem_we, swap_en, ir_load) are 1-cycle pulses. They are never asserted in IDLE, DONE, or non-final MEM cycles.
- busy=1 in FETCH/EXEC/MEM. done=1 only in DONE.
- DONE: holds pc and counters. If start=1, relaunch exactly as from IDLE: done drops the next cycle.
- start is ignored while busy=1.
- cyc_cnt increments every cycle busy=1, saturating at all-ones. instr_cnt saturates likewise.
- Decoder inputs are sampled only in EXEC and the final MEM cycle. Changes elsewhere have no effect.

Decomposition:
- Package seq_pkg:
  - state enum seq_state_t {IDLE, FETCH, EXEC, MEM, DONE}
  - localparam defaults for PC_W/CNT_W
  - saturating-increment function sat_inc
- One sub-module, seq_wait_ctr: loadable down-counter with a zero flag and width $clog2(MEM_LAT+1). The wait counter uses seq_wait_ctr; the PC and performance counters are inline.

Test Plan:
- Reset mid-MEM of a store (reset_n low for 1 cycle) -> mem_we never pulses; pc=0, done=0, busy=0 the same cycle reset asserts.
- start_addr=5; instruction sequence ADD (reg_write=1), halt -> ir_load pulses at cycles 1,3; reg_we pulse at cycle 2 only; done=1 at cycle 4; instr_cnt=1, cyc_cnt=4.
- Store with MEM_LAT=2 (mem_op=1, mem_write=1) -> FETCH, EXEC, MEM, MEM; mem_we asserted exactly once on the 2nd MEM cycle; pc advances by 1 at that cycle.
- BEQ with branch_en=1, target_pc=0x3A: alu_branch=0 -> pc=pc+1; alu_branch=1 -> pc=0x3A. Also jump_en=1 with branch_en=1 and alu_branch=0 -> pc=target_pc.
- pc=0x3FF (PC_W=10), non-branch commit -> pc=0x000, no error. Also start pulsed while busy -> pc and counters unchanged.
- In DONE, assert start with start_addr=0x10 -> done falls the next cycle, pc=0x10, counters cleared, FETCH follows.
